// File: rtl/shift_add_multiplier_pkg.sv
// Shared arithmetic types for the shift-and-add multiplier: FSM state
// encoding, the {carry, upper, lower} product register and a width check.
package shift_add_multiplier_pkg;

  // The product register is sized for the widest supported operand. A given
  // instance only uses the low DATA_WIDTH bits of each half.
  localparam int unsigned MUL_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULTIPLY = 2'd1,
    FINISH   = 2'd2
  } mul_fsm_state_t;

  typedef struct packed {
    logic                     carry;
    logic [MUL_MAX_WIDTH-1:0] upper;
    logic [MUL_MAX_WIDTH-1:0] lower;
  } mul_prod_reg_t;

  function automatic bit mul_width_ok(input int unsigned w);
    return (w >= 4) && (w <= MUL_MAX_WIDTH) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add unsigned multiplier, one partial product per cycle.
// Optional feature: define MUL_ZERO_BYPASS_EN to short-circuit zero operands.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    clk_en_i,
  input  logic [DATA_WIDTH-1:0]   multiplicand_i,
  input  logic [DATA_WIDTH-1:0]   multiplier_i,
  input  logic                    data_valid_i,
  output logic [2*DATA_WIDTH-1:0] product_o,
  output logic                    data_valid_o,
  output logic                    idle_o
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

  if (!mul_width_ok(DATA_WIDTH)) begin : g_width_check
    $error("shift_add_multiplier: DATA_WIDTH must be a power of 2 in [4, %0d]",
           MUL_MAX_WIDTH);
  end

  mul_fsm_state_t        state_q, state_d;
  mul_prod_reg_t         prod_q, prod_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  idle_q, idle_d;
  logic [DATA_WIDTH:0]   sum;

`ifdef MUL_ZERO_BYPASS_EN
  logic operand_zero;
  assign operand_zero = (multiplicand_i == '0) || (multiplier_i == '0);
`endif

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    idle_d  = idle_q;
    sum     = {prod_q.carry, prod_q.upper[DATA_WIDTH-1:0]};

    case (state_q)
      IDLE: begin
        if (data_valid_i) begin
          a_d                          = multiplicand_i;
          prod_d                       = '0;
          prod_d.lower[DATA_WIDTH-1:0] = multiplier_i;
          cnt_d                        = '0;
          idle_d                       = 1'b0;
          state_d                      = MULTIPLY;
`ifdef MUL_ZERO_BYPASS_EN
          if (operand_zero) begin
            prod_d  = '0;
            state_d = FINISH;
          end
`endif
        end
      end

      MULTIPLY: begin
        // Add A into the upper half when the current multiplier bit is set,
        // then shift the whole {carry, upper, lower} register right by one.
        if (prod_q.lower[0]) begin
          sum = {1'b0, prod_q.upper[DATA_WIDTH-1:0]} + {1'b0, a_q};
        end
        prod_d.carry                 = 1'b0;
        prod_d.upper[DATA_WIDTH-1:0] = sum[DATA_WIDTH:1];
        prod_d.lower[DATA_WIDTH-1:0] = {sum[0], prod_q.lower[DATA_WIDTH-1:1]};
        cnt_d                        = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        state_d = IDLE;
        valid_d = 1'b1;
        idle_d  = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      prod_q  <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      idle_q  <= 1'b1;
    end else if (clk_en_i) begin
      state_q <= state_d;
      prod_q  <= prod_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      idle_q  <= idle_d;
    end
  end

  assign product_o    = {prod_q.upper[DATA_WIDTH-1:0], prod_q.lower[DATA_WIDTH-1:0]};
  assign data_valid_o = valid_q;
  assign idle_o       = idle_q;

endmodule
